// File: rtl/common_pkg.sv
// Shared scalar aliases and instruction-bus transaction types.
package common_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  typedef struct packed {
    u1  valid;
    u64 addr;
  } ibus_req_t;

  typedef struct packed {
    u1  data_ok;
    u32 data;
  } ibus_resp_t;

endpackage

// File: rtl/fetch_queue_unit_pkg.sv
// Pipeline-stage types for the fetch queue: decode payload and fetch FSM states.
package fetch_queue_unit_pkg;

  import common_pkg::*;

  typedef struct packed {
    u64 pc;
    u32 raw_instr;
  } fetch_data_t;

  typedef enum logic {
    IDLE,
    REQ
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer with flush; head is zero whenever the buffer is empty.
module fetch_fifo
  import common_pkg::*;
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fetch_data_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  T                         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output T                         head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  T              mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + PW'(1);
      if (do_pop)  head_q <= head_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[tail_q] <= din;
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem[head_q];
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues one outstanding ibus request at a time and
// buffers returned instructions for decode; redirects flush and drop in-flight data.
module fetch_queue_unit
  import common_pkg::*;
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter u64          RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  u64          redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output fetch_data_t dataF,
  output logic        busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t state_q, state_d;
  u64           pc_q, pc_d;
  u64           req_addr_q, req_addr_d;
  logic         drop_q, drop_d;

  logic          enq;
  logic          deq;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after;
  u64            restart_pc;
  fetch_data_t   enq_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
    end
  end

  assign deq = !fifo_empty && out_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    drop_d      = drop_q;
    enq         = 1'b0;
    count_after = fifo_count;
    restart_pc  = redirect_valid ? redirect_pc : pc_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = REQ;
        end else if (!fifo_full) begin
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (!iresp.data_ok) begin
          // Address stays on the bus; the redirect is remembered for the response.
          if (redirect_valid) begin
            drop_d = 1'b1;
            pc_d   = redirect_pc;
          end
        end else if (drop_q || redirect_valid) begin
          drop_d     = 1'b0;
          pc_d       = restart_pc;
          req_addr_d = restart_pc;
        end else begin
          enq         = 1'b1;
          pc_d        = req_addr_q + u64'(PC_STEP);
          count_after = fifo_count + CW'(1) - CW'(deq);
          if (count_after < CW'(DEPTH)) req_addr_d = pc_d;
          else                          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enq_data = '{pc: req_addr_q, raw_instr: iresp.data};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_data_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (enq_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (dataF)
  );

  always_comb begin
    ireq       = '0;
    ireq.valid = (state_q == REQ);
    ireq.addr  = req_addr_q;
  end

  assign out_valid = !fifo_empty;
  assign busy      = ireq.valid && !iresp.data_ok;

  a_addr_stable: assert property (@(posedge clk) disable iff (!reset)
    (ireq.valid && !iresp.data_ok) |=> $stable(ireq.addr));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: expected bus addresses and decode
// entries are queued by the stimulus and popped by a negedge monitor.
module tb_fetch_queue_unit;

  import common_pkg::*;
  import fetch_queue_unit_pkg::*;

  localparam u64 BASE = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  u64          redirect_pc;
  logic        out_valid;
  logic        out_ready;
  fetch_data_t dataF;
  logic        busy;

  logic        ok_en;
  int unsigned ok_delay;
  int unsigned wait_cnt;
  int unsigned done_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  u64          exp_req[$];
  fetch_data_t exp_out[$];

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .DEPTH    (4),
    .RESET_PC (BASE),
    .PC_STEP  (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .dataF          (dataF),
    .busy           (busy)
  );

  function automatic u32 instr_of(input u64 a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Bus model: answers after ok_delay cycles of an outstanding request.
  always_comb begin
    iresp         = '0;
    iresp.data_ok = ireq.valid && ok_en && (wait_cnt >= ok_delay);
    iresp.data    = instr_of(ireq.addr);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset)                             wait_cnt <= 0;
    else if (ireq.valid && !iresp.data_ok) wait_cnt <= wait_cnt + 1;
    else                                    wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_out(input u64 pc);
    fetch_data_t e;
    e.pc        = pc;
    e.raw_instr = instr_of(pc);
    exp_out.push_back(e);
  endtask

  // Monitor: a bus completion or a decode handshake happens at the next posedge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (ireq.valid && iresp.data_ok) begin
        done_cnt++;
        if (exp_req.size() == 0) check("req_unexpected", ireq.addr, 64'hDEAD);
        else                      check("req_addr", ireq.addr, exp_req.pop_front());
      end
      if (out_valid && out_ready && !redirect_valid) begin
        if (exp_out.size() == 0) begin
          check("out_unexpected", dataF.pc, 64'hDEAD);
        end else begin
          fetch_data_t e;
          e = exp_out.pop_front();
          check("out_pc", dataF.pc, e.pc);
          check("out_instr", 64'(dataF.raw_instr), 64'(e.raw_instr));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge on which the n-th further bus completion happens.
  task automatic wait_resps(input int unsigned n);
    int unsigned tgt;
    tgt = done_cnt + n;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= tgt) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("resp_timeout", 64'(done_cnt), 64'(tgt));
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (ireq.valid) return;
      tick();
    end
    check("valid_timeout", 64'(ireq.valid), 64'd1);
  endtask

  task automatic scenario_end();
    check("req_left", 64'(exp_req.size()), 64'd0);
    check("out_left", 64'(exp_out.size()), 64'd0);
    exp_req.delete();
    exp_out.delete();
  endtask

  task automatic do_reset();
    scenario_end();
    reset          = 1'b0;
    ok_en          = 1'b0;
    ok_delay       = 0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    ok_en          = 1'b0;
    ok_delay       = 0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (3) tick();
    check("rst_ireq_valid", 64'(ireq.valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dataF_pc", dataF.pc, 64'd0);
    check("rst_dataF_instr", 64'(dataF.raw_instr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Back-to-back fetch with immediate responses and a ready decoder.
    exp_req.push_back(BASE); exp_req.push_back(BASE + 4); exp_req.push_back(BASE + 8);
    push_out(BASE); push_out(BASE + 4); push_out(BASE + 8);
    ok_en = 1'b1; out_ready = 1'b1; reset = 1'b1;
    wait_resps(1);
    check("s1_out_valid", 64'(out_valid), 64'd1);
    check("s1_head_pc", dataF.pc, BASE);
    check("s1_b2b_addr", ireq.addr, BASE + 4);
    wait_resps(2);
    ok_en = 1'b0;
    repeat (4) tick();
    check("s1_drained", 64'(out_valid), 64'd0);
    check("s1_pending_addr", ireq.addr, BASE + 12);

    // Queue fills with decode stalled, then resumes at the next sequential PC.
    do_reset();
    for (int unsigned i = 0; i < 5; i++) begin
      exp_req.push_back(BASE + 64'(4 * i));
      push_out(BASE + 64'(4 * i));
    end
    ok_en = 1'b1; reset = 1'b1;
    wait_resps(4);
    repeat (3) tick();
    check("s2_idle_valid", 64'(ireq.valid), 64'd0);
    check("s2_idle_busy", 64'(busy), 64'd0);
    check("s2_full_valid", 64'(out_valid), 64'd1);
    check("s2_full_head", dataF.pc, BASE);
    out_ready = 1'b1;
    wait_resps(1);
    ok_en = 1'b0;
    check("s2_resume_valid", 64'(ireq.valid), 64'd1);
    check("s2_resume_addr", ireq.addr, BASE + 20);
    repeat (8) tick();
    check("s2_drained", 64'(out_valid), 64'd0);

    // Slow bus: address held and busy asserted while waiting.
    do_reset();
    exp_req.push_back(BASE);
    push_out(BASE);
    ok_en = 1'b1; ok_delay = 3; out_ready = 1'b1; reset = 1'b1;
    wait_valid();
    for (int unsigned i = 0; i < 3; i++) begin
      check("s3_busy", 64'(busy), 64'd1);
      check("s3_addr_held", ireq.addr, BASE);
      tick();
    end
    check("s3_ok_busy", 64'(busy), 64'd0);
    tick();
    ok_en = 1'b0;
    check("s3_next_addr", ireq.addr, BASE + 4);
    repeat (3) tick();
    check("s3_drained", 64'(out_valid), 64'd0);

    // Redirect while a response is outstanding: flush, discard, restart.
    do_reset();
    exp_req.push_back(BASE); exp_req.push_back(BASE + 4);
    exp_req.push_back(BASE + 8); exp_req.push_back(BASE + 64'h1000);
    push_out(BASE + 64'h1000);
    ok_en = 1'b1; reset = 1'b1;
    wait_resps(2);
    ok_delay = 2;
    check("s4_prefill", 64'(out_valid), 64'd1);
    redirect_pc = BASE + 64'h1000; redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("s4_flushed", 64'(out_valid), 64'd0);
    check("s4_addr_held", ireq.addr, BASE + 8);
    check("s4_busy_held", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_resps(2);
    ok_en = 1'b0;
    repeat (4) tick();
    check("s4_drained", 64'(out_valid), 64'd0);

    // Redirect coinciding with a response and a decode handshake.
    do_reset();
    exp_req.push_back(BASE); exp_req.push_back(BASE + 4);
    exp_req.push_back(BASE + 8); exp_req.push_back(BASE + 64'h2000);
    push_out(BASE + 64'h2000);
    ok_en = 1'b1; reset = 1'b1;
    wait_resps(2);
    check("s5_two_valid", 64'(out_valid), 64'd1);
    check("s5_two_head", dataF.pc, BASE);
    out_ready = 1'b1; redirect_pc = BASE + 64'h2000; redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("s5_empty", 64'(out_valid), 64'd0);
    check("s5_redirect_addr", ireq.addr, BASE + 64'h2000);
    wait_resps(1);
    ok_en = 1'b0;
    repeat (4) tick();
    check("s5_drained", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a request.
    do_reset();
    exp_req.push_back(BASE); exp_req.push_back(BASE + 4); exp_req.push_back(BASE);
    push_out(BASE);
    ok_en = 1'b1; reset = 1'b1;
    wait_resps(2);
    ok_en = 1'b0;
    check("s6_pre_out_valid", 64'(out_valid), 64'd1);
    check("s6_pre_req_valid", 64'(ireq.valid), 64'd1);
    #3 reset = 1'b0;
    #1;
    check("s6_async_req_valid", 64'(ireq.valid), 64'd0);
    check("s6_async_out_valid", 64'(out_valid), 64'd0);
    check("s6_async_dataF", dataF.pc, 64'd0);
    tick();
    ok_en = 1'b1; out_ready = 1'b1; reset = 1'b1;
    wait_resps(1);
    ok_en = 1'b0;
    check("s6_restart_next", ireq.addr, BASE + 4);
    repeat (4) tick();
    check("s6_drained", 64'(out_valid), 64'd0);
    scenario_end();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised fetch stage: owns the PC and issues instruction requests on the ibus.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode through a valid/ready handshake.
- Supports redirect (branch/exception) with queue flush and discard of the in-flight response.
- Sits between the ibus port and decode, replacing the single-cycle pass-through fetch.

Parameters:
- DEPTH, 4, fetch queue entries; power of two, ≥2
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ireq  out  ibus_req_t  request; valid and addr are used, addr is 64 bits
- iresp  in  ibus_resp_t  response; data_ok and data (32 bits) are used
- redirect_valid  in  1  redirect this cycle
- redirect_pc  in  64  redirect target
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head entry
- dataF  out  fetch_data_t  head entry {pc, raw_instr}
- busy  out  1  ireq.valid && !iresp.data_ok, for hazard/perf use

Behaviour:
- Reset (asynchronous, reset==0):
  - state=IDLE, pc_q=RESET_PC, drop_q=0, count=0, head/tail=0.
  - Outputs: ireq.valid=0, out_valid=0, dataF='0.
- Registered request: ireq.valid = (state==REQ); ireq.addr = req_addr_q.
  - While ireq.valid=1, addr is held stable until data_ok, regardless of redirect.
- FSM, IDLE:
  - if redirect_valid: pc_q←redirect_pc, go to REQ with req_addr_q←redirect_pc.
  - else if count<DEPTH: go to REQ with req_addr_q←pc_q.
  - First request is visible one cycle after reset release.
- FSM, REQ, without data_ok:
  - if redirect_valid: drop_q←1, pc_q←redirect_pc; stay in REQ with the old address.
- FSM, REQ, with data_ok, drop_q=0, no redirect:
  - enqueue {req_addr_q, iresp.data}; pc_q←req_addr_q+PC_STEP.
  - if count_next<DEPTH: stay in REQ with req_addr_q←req_addr_q+PC_STEP (back-to-back, 1 instr/cycle).
  - else go to IDLE.
- FSM, REQ, with data_ok and (drop_q=1 or redirect_valid):
  - discard the data; drop_q←0.
  - stay in REQ with req_addr_q←(redirect_valid ? redirect_pc : pc_q); pc_q updated accordingly.
- Queue output:
  - out_valid = count!=0; dataF = entry[head] (combinational from registers). dataF='0 when empty.
  - Dequeue when out_valid && out_ready.
- Redirect flush:
  - All entries are dropped at the edge; count←0; out_valid=0 the next cycle.
  - Redirect overrides a same-cycle enqueue or dequeue.
- Full condition:
  - No issue while count==DEPTH. With a single outstanding request, overflow is impossible.
  - Same-cycle enqueue and dequeue keep count unchanged.
- Arithmetic and widths:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - PC adds are 64-bit and wrap modulo 2^64.
  - redirect_pc is used as-is; no alignment check.
- Assertion: ireq.addr stable while ireq.valid && !iresp.data_ok.

Decomposition:
- common package: u1, u32, u64, ibus_req_t, ibus_resp_t.
- pipes package: fetch_data_t; add fetch_state_t enum {IDLE, REQ}.
- One sub-module: fetch_fifo, parametrised by DEPTH and element type fetch_data_t.
  - Ports: push, pop, flush, full, empty, count, head.
- The FSM and PC logic stay in the top module.

Test Plan:
- Reset release, data_ok tied high, out_ready=1 → requests to 0x80000000, 0x80000004, 0x80000008 in consecutive cycles; dataF.pc follows one cycle behind each response.
- out_ready=0, data_ok immediate, DEPTH=4 → exactly 4 enqueues (pc 0x80000000..0x8000000C), then FSM goes to IDLE with ireq.valid=0. Raising out_ready then resumes fetch at 0x80000010.
- data_ok delayed 3 cycles → ireq.addr held at 0x80000000 and busy=1 for 3 cycles; a single entry is enqueued.
- Redirect to 0x80001000 while a request is pending (data_ok 2 cycles later) → queue empties next cycle; returned data discarded; next request addr is 0x80001000 and the first dequeued pc is 0x80001000.
- Redirect coincident with data_ok and out_ready, queue holding 2 entries → nothing enqueued, count=0, next ireq.addr=redirect_pc.
- Assert reset mid-REQ → ireq.valid and out_valid drop to 0 immediately (asynchronous); after release, fetch restarts at RESET_PC.
